// File: rtl/mux2to1_arbiter.sv
// Round-robin arbiter sharing one registered SIZE-bit output channel between two
// valid/ready requesters; drives the shared 2:1 mux select and tags each word with its source.
module mux2to1_arbiter #(
  parameter int SIZE = 16
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req0_valid,
  input  logic [SIZE-1:0] req0_data,
  output logic            req0_ready,
  input  logic            req1_valid,
  input  logic [SIZE-1:0] req1_data,
  output logic            req1_ready,
  output logic            switch,
  output logic            out_valid,
  output logic [SIZE-1:0] out_data,
  output logic            out_src,
  input  logic            out_ready
);

  typedef enum logic {EMPTY = 1'b0, FULL = 1'b1} state_e;

  state_e          state_q, state_d;
  logic            last_q, last_d;
  logic [SIZE-1:0] data_q, data_d;
  logic            src_q, src_d;

  logic            any_req, g, can_load, load;
  logic [SIZE-1:0] mux_data;

  // A draining register may reload in the same cycle, keeping 1 word/cycle.
  always_comb begin
    any_req  = req0_valid | req1_valid;
    g        = (req0_valid & req1_valid) ? ~last_q : req1_valid;
    can_load = (state_q == EMPTY) | out_ready;
    load     = can_load & any_req;
  end

  assign mux_data = switch ? req1_data : req0_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      last_q  <= 1'b1;
      data_q  <= '0;
      src_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      last_q  <= last_d;
      data_q  <= data_d;
      src_q   <= src_d;
    end
  end

  always_comb begin
    state_d = state_q;
    last_d  = last_q;
    data_d  = data_q;
    src_d   = src_q;
    if (load) begin
      state_d = FULL;
      data_d  = mux_data;
      src_d   = g;
      last_d  = g;
    end else if ((state_q == FULL) && out_ready) begin
      state_d = EMPTY;
    end
  end

  // Readies are masked while reset is held so nothing appears accepted.
  always_comb begin
    switch     = any_req ? g : last_q;
    req0_ready = ~rst & can_load & req0_valid & ~g;
    req1_ready = ~rst & can_load & req1_valid & g;
    out_valid  = (state_q == FULL);
    out_data   = data_q;
    out_src    = src_q;
  end

endmodule

// File: tb/tb_mux2to1_arbiter.sv
// Self-checking bench for mux2to1_arbiter: directed vector table, reset corner
// sequences, and randomized traffic checked against a transaction-level model.
module tb_mux2to1_arbiter;
  localparam int SIZE = 16;

  logic            clk = 1'b0;
  logic            rst;
  logic            req0_valid, req1_valid, req0_ready, req1_ready;
  logic [SIZE-1:0] req0_data, req1_data, out_data;
  logic            switch, out_valid, out_src, out_ready;

  int n_cmp = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mux2to1_arbiter #(.SIZE(SIZE)) dut (
    .clk(clk), .rst(rst),
    .req0_valid(req0_valid), .req0_data(req0_data), .req0_ready(req0_ready),
    .req1_valid(req1_valid), .req1_data(req1_data), .req1_ready(req1_ready),
    .switch(switch), .out_valid(out_valid), .out_data(out_data), .out_src(out_src),
    .out_ready(out_ready)
  );

  typedef struct {
    logic v0, v1;
    logic [15:0] d0, d1;
    logic ordy;
    logic r0, r1, sw, ov;
    logic [15:0] od;
    logic osrc;
  } vec_t;

  vec_t tbl[17];

  function automatic vec_t mk(logic v0, logic v1, logic [15:0] d0, logic [15:0] d1, logic ordy,
                              logic r0, logic r1, logic sw, logic ov, logic [15:0] od, logic osrc);
    vec_t t;
    t.v0 = v0; t.v1 = v1; t.d0 = d0; t.d1 = d1; t.ordy = ordy;
    t.r0 = r0; t.r1 = r1; t.sw = sw; t.ov = ov; t.od = od; t.osrc = osrc;
    return t;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic v0, input logic v1, input logic [15:0] d0,
                       input logic [15:0] d1, input logic ordy);
    req0_valid = v0; req1_valid = v1; req0_data = d0; req1_data = d1; out_ready = ordy;
  endtask

  // Transaction-level model: one-entry buffer plus the requester currently favoured.
  logic        m_full;
  logic [15:0] m_data;
  logic        m_src;
  int          m_prio;

  task automatic model_reset();
    m_full = 1'b0; m_data = '0; m_src = 1'b0; m_prio = 0;
  endtask

  task automatic model_step(input logic v0, input logic v1, input logic [15:0] d0,
                            input logic [15:0] d1, input logic ordy,
                            output logic e0, output logic e1);
    int  w;
    bit  has;
    bit  room;
    logic esw;
    has  = v0 || v1;
    room = !m_full || ordy;
    if (v0 && v1) w = m_prio;
    else          w = v1 ? 1 : 0;
    esw = has ? logic'(w) : logic'(1 - m_prio);
    e0  = room && has && (w == 0);
    e1  = room && has && (w == 1);
    chk("rnd_ready0", req0_ready, e0);
    chk("rnd_ready1", req1_ready, e1);
    chk("rnd_switch", switch, esw);
    chk("rnd_out_valid", out_valid, m_full);
    if (m_full) begin
      chk("rnd_out_data", out_data, m_data);
      chk("rnd_out_src", out_src, m_src);
    end
    if (room && has) begin
      m_full = 1'b1;
      m_data = (w == 1) ? d1 : d0;
      m_src  = logic'(w);
      m_prio = 1 - w;
    end else if (m_full && ordy) begin
      m_full = 1'b0;
    end
  endtask

  initial begin
    logic        p0, p1, e0, e1, ordy;
    logic [15:0] pd0, pd1;

    // Contention from reset, backpressure, priority under stall, single requester, idle.
    tbl[0]  = mk(1,1,16'hAAAA,16'h5555,1, 1,0,0, 0,16'h0000,0);
    tbl[1]  = mk(1,1,16'hAAAA,16'h5555,1, 0,1,1, 1,16'hAAAA,0);
    tbl[2]  = mk(1,1,16'hAAAA,16'h5555,1, 1,0,0, 1,16'h5555,1);
    tbl[3]  = mk(1,1,16'hAAAA,16'h5555,0, 0,0,1, 1,16'hAAAA,0);
    tbl[4]  = mk(1,1,16'hAAAA,16'h5555,0, 0,0,1, 1,16'hAAAA,0);
    tbl[5]  = mk(1,1,16'hAAAA,16'h5555,0, 0,0,1, 1,16'hAAAA,0);
    tbl[6]  = mk(1,1,16'hAAAA,16'h5555,1, 0,1,1, 1,16'hAAAA,0);
    tbl[7]  = mk(0,1,16'h0000,16'h0B0B,1, 0,1,1, 1,16'h5555,1);
    tbl[8]  = mk(1,1,16'h0A0A,16'h0B0C,0, 0,0,0, 1,16'h0B0B,1);
    tbl[9]  = mk(1,1,16'h0A0A,16'h0B0C,1, 1,0,0, 1,16'h0B0B,1);
    tbl[10] = mk(1,0,16'h1111,16'h0000,1, 1,0,0, 1,16'h0A0A,0);
    tbl[11] = mk(1,0,16'h2222,16'h0000,1, 1,0,0, 1,16'h1111,0);
    tbl[12] = mk(1,0,16'h3333,16'h0000,1, 1,0,0, 1,16'h2222,0);
    tbl[13] = mk(0,0,16'h0000,16'h0000,1, 0,0,0, 1,16'h3333,0);
    tbl[14] = mk(0,0,16'h0000,16'h0000,0, 0,0,0, 0,16'h3333,0);
    tbl[15] = mk(0,1,16'h0000,16'h7777,0, 0,1,1, 0,16'h3333,0);
    tbl[16] = mk(0,0,16'h0000,16'h0000,0, 0,0,1, 1,16'h7777,1);

    // Reset with both requesters asserting valid.
    rst = 1'b1;
    drive(1, 1, 16'hAAAA, 16'h5555, 1);
    repeat (3) @(negedge clk);
    #1;
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_out_data", out_data, 16'h0);
    chk("rst_ready0", req0_ready, 1'b0);
    chk("rst_ready1", req1_ready, 1'b0);

    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 17; i++) begin
      if (i > 0) @(negedge clk);
      drive(tbl[i].v0, tbl[i].v1, tbl[i].d0, tbl[i].d1, tbl[i].ordy);
      #1;
      chk($sformatf("vec%0d_ready0", i), req0_ready, tbl[i].r0);
      chk($sformatf("vec%0d_ready1", i), req1_ready, tbl[i].r1);
      chk($sformatf("vec%0d_switch", i), switch, tbl[i].sw);
      chk($sformatf("vec%0d_out_valid", i), out_valid, tbl[i].ov);
      chk($sformatf("vec%0d_out_data", i), out_data, tbl[i].od);
      chk($sformatf("vec%0d_out_src", i), out_src, tbl[i].osrc);
    end

    // Reset mid-transfer discards a buffered word asynchronously.
    @(negedge clk);
    drive(1, 0, 16'hBEEF, 16'h0000, 1);
    #1 chk("beef_ready0", req0_ready, 1'b1);
    @(negedge clk);
    drive(0, 0, 16'h0000, 16'h0000, 0);
    #1;
    chk("beef_out_valid", out_valid, 1'b1);
    chk("beef_out_data", out_data, 16'hBEEF);
    #1 rst = 1'b1;
    #1;
    chk("midrst_out_valid", out_valid, 1'b0);
    chk("midrst_out_data", out_data, 16'h0);
    @(negedge clk);
    rst = 1'b0;
    drive(1, 1, 16'hAAAA, 16'h5555, 1);
    #1;
    chk("postrst_ready0", req0_ready, 1'b1);
    chk("postrst_ready1", req1_ready, 1'b0);
    chk("postrst_switch", switch, 1'b0);
    @(negedge clk);
    #1;
    chk("postrst_out_data", out_data, 16'hAAAA);
    chk("postrst_out_src", out_src, 1'b0);
    chk("postrst_ready1b", req1_ready, 1'b1);

    // Randomized traffic; requesters hold valid/data until accepted.
    @(negedge clk);
    rst = 1'b1;
    drive(0, 0, 16'h0, 16'h0, 0);
    #2 rst = 1'b0;
    model_reset();
    p0 = 1'b0; p1 = 1'b0; pd0 = '0; pd1 = '0;
    for (int c = 0; c < 400; c++) begin
      @(negedge clk);
      if (!p0) begin p0 = ($urandom_range(0, 99) < 60); pd0 = 16'($urandom); end
      if (!p1) begin p1 = ($urandom_range(0, 99) < 60); pd1 = 16'($urandom); end
      ordy = ($urandom_range(0, 99) < 70);
      drive(p0, p1, pd0, pd1, ordy);
      #1;
      model_step(p0, p1, pd0, pd1, ordy, e0, e1);
      if (e0) p0 = 1'b0;
      if (e1) p1 = 1'b0;
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
